// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: shared FSM state type and default vector layout for the interrupt front end
package irq_arbiter_pkg;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE} irq_state_t;
  localparam logic [15:0] VEC_BASE_DEF = 16'h0100;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'h0010;
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchronizer plus delay flop, emits a one-cycle rising-edge pulse per line
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] s1_q, s2_q, s3_q;
  // Ones at reset so a line held high through reset is not seen as an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= '1;
      s2_q <= '1;
      s3_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches synchronized interrupt edges and presents the lowest unmasked pending source
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int          N_IRQ      = 8,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IRQ-1:0]           irq_in,
  input  logic                       mask_we,
  input  logic [N_IRQ-1:0]           mask_wdata,
  input  logic                       pend_clr_we,
  input  logic [N_IRQ-1:0]           pend_clr_mask,
  input  logic                       irq_ack,
  input  logic                       irq_done,
  output logic                       irq_req,
  output logic [15:0]                irq_vec,
  output logic [$clog2(N_IRQ)-1:0]   irq_id,
  output logic [N_IRQ-1:0]           pending,
  output logic [N_IRQ-1:0]           mask,
  output logic                       busy
);
  localparam int IW = $clog2(N_IRQ);
  irq_state_t state_q;
  logic [N_IRQ-1:0] rise, pend_q, pend_d, mask_q, clr;
  logic [IW-1:0] id_q, sel;
  logic [15:0] vec_q;
  logic req_q, busy_q, ack_ok;
  function automatic logic [IW-1:0] lowest(input logic [N_IRQ-1:0] v);
    lowest = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (v[i]) lowest = IW'(i);
  endfunction
  irq_sync_edge #(.W(N_IRQ)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_i   (irq_in),
    .rise_o(rise)
  );
  assign ack_ok = (state_q == IRQ_REQ) && irq_ack;
  assign sel    = lowest(pend_q & mask_q);
  // A same-cycle edge overrides any clear so no request is lost
  always_comb begin
    clr    = (pend_clr_we ? pend_clr_mask : '0) | (ack_ok ? {{(N_IRQ-1){1'b0}}, 1'b1} << id_q : '0);
    pend_d = (pend_q & ~clr) | rise;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IRQ_IDLE;
      id_q    <= '0;
      vec_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: if (|(pend_q & mask_q)) begin
          state_q <= IRQ_REQ;
          id_q    <= sel;
          vec_q   <= VEC_BASE + 16'(sel) * VEC_STRIDE;
          req_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
        IRQ_REQ: if (irq_ack) begin
          state_q <= IRQ_SERVICE;
          req_q   <= 1'b0;
        end
        IRQ_SERVICE: if (irq_done) begin
          state_q <= IRQ_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IRQ_IDLE;
      endcase
    end
  end
  assign irq_req = req_q;
  assign irq_vec = vec_q;
  assign irq_id  = id_q;
  assign pending = pend_q;
  assign mask    = mask_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed vectors against hand-computed expectations for both 8- and 16-line builds
module tb_irq_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] irq_in = '0, mask_wdata = '0, pend_clr_mask = '0, pending, mask;
  logic mask_we = 0, pend_clr_we = 0, irq_ack = 0, irq_done = 0, irq_req, busy;
  logic [15:0] irq_vec;
  logic [2:0] irq_id;
  logic [15:0] irq_in16 = '0, mask_wdata16 = '0, pending16, mask16, irq_vec16;
  logic mask_we16 = 0, irq_req16, busy16;
  logic [3:0] irq_id16;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  irq_arbiter u_dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pend_clr_we(pend_clr_we), .pend_clr_mask(pend_clr_mask), .irq_ack(irq_ack),
    .irq_done(irq_done), .irq_req(irq_req), .irq_vec(irq_vec), .irq_id(irq_id),
    .pending(pending), .mask(mask), .busy(busy)
  );
  irq_arbiter #(.N_IRQ(16), .VEC_BASE(16'hFF00), .VEC_STRIDE(16'h0020)) u_dut16 (
    .clk(clk), .rst(rst), .irq_in(irq_in16), .mask_we(mask_we16), .mask_wdata(mask_wdata16),
    .pend_clr_we(1'b0), .pend_clr_mask(16'h0000), .irq_ack(1'b0),
    .irq_done(1'b0), .irq_req(irq_req16), .irq_vec(irq_vec16), .irq_id(irq_id16),
    .pending(pending16), .mask(mask16), .busy(busy16)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_mask(input logic [7:0] m);
    mask_we = 1; mask_wdata = m;
    step(1);
    mask_we = 0;
  endtask
  task automatic ack_done();
    irq_ack = 1; step(1); irq_ack = 0;
    irq_done = 1; step(1); irq_done = 0;
  endtask
  initial begin
    irq_in = 8'h04;
    step(3);
    check("rst_req", irq_req, 0);
    check("rst_vec", irq_vec, 0);
    check("rst_busy", busy, 0);
    rst = 1;
    step(6);
    check("held_high_no_pend", pending, 8'h00);
    check("held_high_no_req", irq_req, 0);
    set_mask(8'h04);
    irq_in = 8'h00;
    step(4);
    irq_in = 8'h04;
    step(3);
    check("lat_req_k2", irq_req, 0);
    check("lat_pend_k2", pending, 8'h04);
    step(1);
    check("lat_req_k3", irq_req, 1);
    check("lat_id", irq_id, 2);
    check("lat_vec", irq_vec, 16'h0120);
    check("lat_busy", busy, 1);
    irq_ack = 1; step(1); irq_ack = 0;
    check("ack_req", irq_req, 0);
    check("ack_pend", pending, 8'h00);
    check("ack_busy", busy, 1);
    irq_done = 1; step(1); irq_done = 0;
    check("done_busy", busy, 0);
    set_mask(8'hFF);
    irq_in = 8'h26;
    step(4);
    check("pri_req", irq_req, 1);
    check("pri_id", irq_id, 1);
    check("pri_vec", irq_vec, 16'h0110);
    check("pri_pend", pending, 8'h22);
    irq_ack = 1; step(1); irq_ack = 0;
    check("pri_ack_pend", pending, 8'h20);
    irq_done = 1; step(1); irq_done = 0;
    check("pri_idle_gap", irq_req, 0);
    step(1);
    check("pri2_req", irq_req, 1);
    check("pri2_id", irq_id, 5);
    check("pri2_vec", irq_vec, 16'h0150);
    ack_done();
    set_mask(8'h00);
    irq_in = 8'h2E;
    step(4);
    check("masked_pend", pending, 8'h08);
    check("masked_req", irq_req, 0);
    set_mask(8'h08);
    check("mask_delay_req", irq_req, 0);
    step(1);
    check("mask_on_req", irq_req, 1);
    check("mask_on_id", irq_id, 3);
    check("mask_on_vec", irq_vec, 16'h0130);
    ack_done();
    irq_in = 8'h3E;
    step(2);
    pend_clr_we = 1; pend_clr_mask = 8'h10;
    step(1);
    check("edge_beats_clr", pending, 8'h10);
    step(1);
    pend_clr_we = 0;
    check("clr_alone", pending, 8'h00);
    set_mask(8'h40);
    irq_in = 8'h7E;
    step(4);
    check("svc_req", irq_req, 1);
    check("svc_id", irq_id, 6);
    irq_ack = 1; step(1);
    irq_in = 8'hFE;
    step(1); irq_ack = 0;
    check("stray_ack_busy", busy, 1);
    check("stray_ack_req", irq_req, 0);
    step(2);
    check("svc_accum_pend", pending, 8'h80);
    check("svc_still_busy", busy, 1);
    rst = 0; step(1); rst = 1;
    check("mid_rst_req", irq_req, 0);
    check("mid_rst_pend", pending, 8'h00);
    check("mid_rst_mask", mask, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vec", irq_vec, 0);
    mask_we16 = 1; mask_wdata16 = 16'hFFFF; step(1); mask_we16 = 0;
    irq_in16 = 16'h8000;
    step(3);
    check("w16_req_k2", irq_req16, 0);
    step(1);
    check("w16_req", irq_req16, 1);
    check("w16_id", irq_id16, 15);
    check("w16_vec_wrap", irq_vec16, 16'h00E0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
